// File: rtl/multi_buffer_controller.sv
// Frame FIFO controller over BUFFER_NUM slots of one shared dual-port RAM, one producer, one consumer.
// Optional frame abort on the write side is enabled by defining WR_ABORT_EN (adds port wr_abort_i).
module multi_buffer_controller #(
   parameter int WRITE_DATA_WIDTH = 64,
   parameter int WRITE_DATA_DEPTH = 256,
   parameter int READ_DATA_WIDTH  = 256,
   parameter int READ_DATA_DEPTH  = 64,
   parameter int BUFFER_NUM       = 4
) (
   input  logic                                                     clk_i,
   input  logic                                                     rst_i,
`ifdef WR_ABORT_EN
   input  logic                                                     wr_abort_i,
`endif
   input  logic                                                     wr_req_i,
   output logic                                                     wr_req_ack_o,
   output logic                                                     wr_req_result_o,
   output logic [$clog2(BUFFER_NUM)-1:0]                            wr_slot_o,
   input  logic                                                     wr_en_i,
   input  logic [WRITE_DATA_WIDTH-1:0]                              wr_data_i,
   input  logic [$clog2(WRITE_DATA_DEPTH)-1:0]                      wr_addr_i,
   input  logic                                                     wr_finish_i,
   output logic                                                     wr_finish_ack_o,
   input  logic                                                     rd_req_i,
   output logic                                                     rd_req_ack_o,
   output logic                                                     rd_req_result_o,
   output logic [$clog2(BUFFER_NUM)-1:0]                            rd_slot_o,
   input  logic [$clog2(READ_DATA_DEPTH)-1:0]                       rd_addr_i,
   output logic [READ_DATA_WIDTH-1:0]                               rd_data_o,
   input  logic                                                     rd_finish_i,
   output logic                                                     rd_finish_ack_o,
   output logic                                                     ram_wr_en_o,
   output logic [WRITE_DATA_WIDTH-1:0]                              ram_wr_data_o,
   output logic [$clog2(BUFFER_NUM)+$clog2(WRITE_DATA_DEPTH)-1:0]   ram_wr_addr_o,
   output logic [$clog2(BUFFER_NUM)+$clog2(READ_DATA_DEPTH)-1:0]    ram_rd_addr_o,
   input  logic [READ_DATA_WIDTH-1:0]                               ram_rd_data_i,
   output logic [$clog2(BUFFER_NUM):0]                              count_o,
   output logic                                                     full_o,
   output logic                                                     empty_o
);

   localparam int BUF_AW = $clog2(BUFFER_NUM);
   localparam int WR_AW  = $clog2(WRITE_DATA_DEPTH);
   localparam logic [BUF_AW:0] FULL_CNT = (BUF_AW+1)'(BUFFER_NUM);

   typedef enum logic [2:0] {
      S_IDLE, S_ACK, S_ACTIVE, S_HOLD, S_FIN, S_FWAIT
   } state_e;

   // Handshake: req/finish are levels held by the client until the matching
   // one-cycle ack; after an ack the level must be seen low before it is re-armed.
   state_e                  wr_state_q, rd_state_q;
   logic [BUF_AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [BUF_AW:0]         count_q, count_d;
   logic                    wr_ack_q, wr_result_q, wr_fin_ack_q;
   logic                    rd_ack_q, rd_result_q, rd_fin_ack_q;
   logic                    ram_wr_en_q;
   logic [WRITE_DATA_WIDTH-1:0]   ram_wr_data_q;
   logic [BUF_AW+WR_AW-1:0] ram_wr_addr_q;
   logic                    wr_abort;
   logic                    wr_close, wr_commit, rd_release;

`ifdef WR_ABORT_EN
   assign wr_abort = wr_abort_i;
`else
   assign wr_abort = 1'b0;
`endif

   assign wr_close   = (wr_state_q == S_ACTIVE) && (wr_finish_i || wr_abort);
   assign wr_commit  = (wr_state_q == S_ACTIVE) && wr_finish_i && !wr_abort;
   assign rd_release = (rd_state_q == S_ACTIVE) && rd_finish_i;

   always_comb begin
      count_d = count_q;
      case ({wr_commit, rd_release})
         2'b10:   count_d = count_q + (BUF_AW+1)'(1);
         2'b01:   count_d = count_q - (BUF_AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) count_q <= '0;
      else       count_q <= count_d;
   end

   // Write side FSM; grant decision uses the count registered at the request edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_state_q    <= S_IDLE;
         wr_ptr_q      <= '0;
         wr_ack_q      <= 1'b0;
         wr_result_q   <= 1'b0;
         wr_fin_ack_q  <= 1'b0;
         ram_wr_en_q   <= 1'b0;
         ram_wr_data_q <= '0;
         ram_wr_addr_q <= '0;
      end else begin
         wr_ack_q     <= 1'b0;
         wr_fin_ack_q <= 1'b0;
         ram_wr_en_q  <= 1'b0;
         case (wr_state_q)
            S_IDLE: begin
               if (wr_req_i) begin
                  wr_state_q  <= S_ACK;
                  wr_ack_q    <= 1'b1;
                  wr_result_q <= (count_q < FULL_CNT);
               end
            end
            S_ACK: begin
               wr_result_q <= 1'b0;
               wr_state_q  <= wr_result_q ? S_ACTIVE : S_HOLD;
            end
            S_ACTIVE: begin
               if (wr_en_i) begin
                  ram_wr_en_q   <= 1'b1;
                  ram_wr_data_q <= wr_data_i;
                  ram_wr_addr_q <= {wr_ptr_q, wr_addr_i};
               end
               if (wr_close) begin
                  wr_state_q   <= S_FIN;
                  wr_fin_ack_q <= 1'b1;
                  if (wr_commit) wr_ptr_q <= wr_ptr_q + BUF_AW'(1);
               end
            end
            S_HOLD:  if (!wr_req_i) wr_state_q <= S_IDLE;
            S_FIN:   wr_state_q <= S_FWAIT;
            S_FWAIT: if (!wr_finish_i && !wr_abort) wr_state_q <= S_IDLE;
            default: wr_state_q <= S_IDLE;
         endcase
      end
   end

   // Read side FSM; the slot stays counted as occupied until its release.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_state_q   <= S_IDLE;
         rd_ptr_q     <= '0;
         rd_ack_q     <= 1'b0;
         rd_result_q  <= 1'b0;
         rd_fin_ack_q <= 1'b0;
      end else begin
         rd_ack_q     <= 1'b0;
         rd_fin_ack_q <= 1'b0;
         case (rd_state_q)
            S_IDLE: begin
               if (rd_req_i) begin
                  rd_state_q  <= S_ACK;
                  rd_ack_q    <= 1'b1;
                  rd_result_q <= (count_q != '0);
               end
            end
            S_ACK: begin
               rd_result_q <= 1'b0;
               rd_state_q  <= rd_result_q ? S_ACTIVE : S_HOLD;
            end
            S_ACTIVE: begin
               if (rd_release) begin
                  rd_state_q   <= S_FIN;
                  rd_fin_ack_q <= 1'b1;
                  rd_ptr_q     <= rd_ptr_q + BUF_AW'(1);
               end
            end
            S_HOLD:  if (!rd_req_i) rd_state_q <= S_IDLE;
            S_FIN:   rd_state_q <= S_FWAIT;
            S_FWAIT: if (!rd_finish_i) rd_state_q <= S_IDLE;
            default: rd_state_q <= S_IDLE;
         endcase
      end
   end

   assign wr_req_ack_o    = wr_ack_q;
   assign wr_req_result_o = wr_result_q;
   assign wr_slot_o       = wr_ptr_q;
   assign wr_finish_ack_o = wr_fin_ack_q;
   assign rd_req_ack_o    = rd_ack_q;
   assign rd_req_result_o = rd_result_q;
   assign rd_slot_o       = rd_ptr_q;
   assign rd_finish_ack_o = rd_fin_ack_q;
   assign ram_wr_en_o     = ram_wr_en_q;
   assign ram_wr_data_o   = ram_wr_data_q;
   assign ram_wr_addr_o   = ram_wr_addr_q;
   assign ram_rd_addr_o   = {rd_ptr_q, rd_addr_i};
   assign rd_data_o       = ram_rd_data_i;
   assign count_o         = count_q;
   assign full_o          = (count_q == FULL_CNT);
   assign empty_o         = (count_q == '0);

endmodule
